// File: rtl/tpum_apb_master.sv
// APB master that issues single/burst register transfers to the TPUM register file.
// Each beat is one APB transfer at an auto-incremented address; stalled slaves abort after TIMEOUT ACCESS cycles.
module tpum_apb_master #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned LEN_W    = 6,
   parameter int unsigned ADDR_INC = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   output logic              done,
   output logic              done_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {IDLE, WDATA, SETUP, ACCESS} state_t;

   localparam logic [ADDR_W-1:0] INC     = ADDR_W'(ADDR_INC);
   localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                write_q, write_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [15:0]         to_q, to_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_err_q, rd_err_d;
   logic                done_q, done_d;
   logic                done_err_q, done_err_d;

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      to_d       = to_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      done_d     = 1'b0;
      done_err_d = done_err_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               write_d  = cmd_write;
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               cnt_d    = cmd_len;
               err_d    = 1'b0;
               state_d  = cmd_write ? WDATA : SETUP;
            end
         end
         WDATA: begin
            if (wr_valid) begin
               pwdata_d = wr_data;
               state_d  = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (pready) begin
               if (!write_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = prdata;
                  rd_err_d   = pslverr;
               end
               err_d = err_q | pslverr;
               if (cnt_q != '0) begin
                  paddr_d = paddr_q + INC;
                  cnt_d   = cnt_q - 1'b1;
                  state_d = write_q ? WDATA : SETUP;
               end else begin
                  done_d     = 1'b1;
                  done_err_d = err_q | pslverr;
                  state_d    = IDLE;
               end
            end else if (to_q == TO_LAST) begin
               // Abort: the stalled beat and any remaining beats are dropped.
               if (!write_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = '0;
                  rd_err_d   = 1'b1;
               end
               done_d     = 1'b1;
               done_err_d = 1'b1;
               state_d    = IDLE;
            end else begin
               to_d = to_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == SETUP) to_d = '0;
      psel_d    = (state_d == SETUP) || (state_d == ACCESS);
      penable_d = (state_d == ACCESS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         to_q       <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         to_q       <= to_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
         done_q     <= done_d;
         done_err_q <= done_err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign wr_ready  = (state_q == WDATA);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_err    = rd_err_q;
   assign done      = done_q;
   assign done_err  = done_err_q;

endmodule
